// File: rtl/up_core.sv
// Single-accumulator two-phase (fetch/execute) core with hardware call stack
// and a req/ack data-RAM port that can stall execution.
module up_core #(
  parameter int DATA_W      = 4,
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 4,
  localparam int IW         = 4 + DATA_W + ADDR_W,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IW-1:0]     rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_we,
  output logic              ram_req,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic              out_strobe,
  output logic [DATA_W-1:0] acc,
  output logic              c_flag,
  output logic              z_flag,
  output logic              phase,
  output logic [SP_W-1:0]   sp,
  output logic              stack_err
);

  localparam logic [3:0] OP_JC   = 4'h1;
  localparam logic [3:0] OP_JNC  = 4'h2;
  localparam logic [3:0] OP_CMPI = 4'h3;
  localparam logic [3:0] OP_CMPM = 4'h4;
  localparam logic [3:0] OP_LIT  = 4'h5;
  localparam logic [3:0] OP_IN   = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_ADDM = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_OUT  = 4'hD;
  localparam logic [3:0] OP_CALL = 4'hE;
  localparam logic [3:0] OP_RET  = 4'hF;

  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [1:0] {FETCH, EXEC, WAIT} state_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       ir;
  logic [ADDR_W-1:0]   pc;
  logic [3:0]          op;
  logic [DATA_W-1:0]   imm;
  logic [ADDR_W-1:0]   addr;
  logic                ram_op;
  logic                commit;
  logic [DATA_W-1:0]   operand;
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;
  logic [SP_W-1:0]     sp_dec;
  logic [ADDR_W-1:0]   stack_mem [2**SP_W];

  assign op       = ir[IW-1 -: 4];
  assign imm      = ir[ADDR_W +: DATA_W];
  assign addr     = ir[ADDR_W-1:0];
  assign ram_op   = (op == OP_CMPM) || (op == OP_LD) || (op == OP_ST) || (op == OP_ADDM);
  assign rom_addr = pc;
  assign ram_addr = addr;
  assign ram_wdata = acc;
  assign sp_dec   = sp - SP_W'(1);

  // A RAM instruction commits only in its ack cycle; all others at the end of EXEC.
  assign commit   = ((state == EXEC) && !ram_op) || (ram_req && ram_ack);

  assign operand  = ram_op ? ram_rdata : imm;
  assign sum      = {1'b0, acc} + {1'b0, operand};
  assign diff     = {1'b0, acc} - {1'b0, operand};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   state_nxt = EXEC;
      EXEC:    state_nxt = (ram_op && !ram_ack) ? WAIT : FETCH;
      WAIT:    state_nxt = ram_ack ? FETCH : WAIT;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    phase   = (state != FETCH);
    ram_req = (state != FETCH) && ram_op;
    ram_we  = (state != FETCH) && ram_op && (op == OP_ST);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= '0;
      ir         <= '0;
      acc        <= '0;
      c_flag     <= 1'b0;
      z_flag     <= 1'b0;
      sp         <= '0;
      stack_err  <= 1'b0;
      out_port   <= '0;
      out_strobe <= 1'b0;
    end else begin
      out_strobe <= 1'b0;
      if (state == FETCH) begin
        ir <= rom_data;
        pc <= pc + ADDR_W'(1);
      end else if (commit) begin
        case (op)
          OP_JC:   if (c_flag)  pc <= addr;
          OP_JNC:  if (!c_flag) pc <= addr;
          OP_JZ:   if (z_flag)  pc <= addr;
          OP_JMP:  pc <= addr;
          OP_CMPI, OP_CMPM: begin
            c_flag <= diff[DATA_W];
            z_flag <= (diff[DATA_W-1:0] == '0);
          end
          OP_ADDI, OP_ADDM: begin
            acc    <= sum[DATA_W-1:0];
            c_flag <= sum[DATA_W];
            z_flag <= (sum[DATA_W-1:0] == '0);
          end
          OP_LIT:  acc <= imm;
          OP_IN:   acc <= in_port;
          OP_LD:   acc <= ram_rdata;
          OP_OUT: begin
            out_port   <= acc;
            out_strobe <= 1'b1;
          end
          OP_CALL: begin
            if (sp == SP_FULL) stack_err <= 1'b1;
            else begin
              sp <= sp + SP_W'(1);
              pc <= addr;
            end
          end
          OP_RET: begin
            if (sp == '0) stack_err <= 1'b1;
            else begin
              sp <= sp_dec;
              pc <= stack_mem[sp_dec];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Return addresses are pure data: the occupancy counter alone says which are live.
  always_ff @(posedge clock) begin
    if ((state == EXEC) && (op == OP_CALL) && (sp != SP_FULL))
      stack_mem[sp] <= pc;
  end

endmodule
